// File: rtl/hazard_tracker.sv
// hazard_tracker: consumer side of the decode-stage Tuse/Tnew handshake for a
// 5-stage MIPS pipeline. It keeps a shadow pipeline of destination register
// and Tnew for E/M/W. From that it decides, every cycle, whether D must stall
// and which forwarding source the D-stage and E-stage operand muxes select.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   rs_D, rt_D        source registers of the instruction in D
//   Tuse_rs, Tuse_rt  cycles until D consumes the operand (7 = unused)
//   A3_D, Tnew_D      destination register (0 = none) and latency at E entry
//   stall             hold PC and IF/ID, bubble into E
//   FwdRs_D/FwdRt_D   D mux select: 0 RF, 1 E, 2 M, 3 W
//   FwdRs_E/FwdRt_E   E mux select: 0 pipeline reg, 2 M, 3 W

// One source operand: stall decision plus D- and E-stage forward selects.
module hazard_src #(
  parameter int RA_W = 5,
  parameter int T_W  = 3
) (
  input  logic [RA_W-1:0] src_d,
  input  logic [T_W-1:0]  tuse,
  input  logic [RA_W-1:0] src_e,
  input  logic [RA_W-1:0] a3_e,
  input  logic [T_W-1:0]  tnew_e,
  input  logic [RA_W-1:0] a3_m,
  input  logic [T_W-1:0]  tnew_m,
  input  logic [RA_W-1:0] a3_w,
  output logic            stall,
  output logic [1:0]      fwd_d,
  output logic [1:0]      fwd_e
);
  logic d_nz, e_nz;
  logic d_hit_e, d_hit_m, d_hit_w;
  logic e_hit_m, e_hit_w;

  // $0 never matches; bubbles carry A3=0 so they are filtered by the same guard.
  assign d_nz    = (src_d != '0);
  assign e_nz    = (src_e != '0);
  assign d_hit_e = d_nz && (src_d == a3_e);
  assign d_hit_m = d_nz && (src_d == a3_m);
  assign d_hit_w = d_nz && (src_d == a3_w);
  assign e_hit_m = e_nz && (src_e == a3_m);
  assign e_hit_w = e_nz && (src_e == a3_w);

  // Tuse=7 can never be below Tnew (max 2), so unused operands never stall.
  assign stall = (d_hit_e && (tuse < tnew_e)) || (d_hit_m && (tuse < tnew_m));

  // Youngest matching stage wins; a not-yet-ready youngest match selects 0 so
  // an older, stale copy is never forwarded.
  always_comb begin
    fwd_d = 2'd0;
    if (d_hit_e)      fwd_d = (tnew_e == '0) ? 2'd1 : 2'd0;
    else if (d_hit_m) fwd_d = (tnew_m == '0) ? 2'd2 : 2'd0;
    else if (d_hit_w) fwd_d = 2'd3;
  end

  always_comb begin
    fwd_e = 2'd0;
    if (e_hit_m)      fwd_e = (tnew_m == '0) ? 2'd2 : 2'd0;
    else if (e_hit_w) fwd_e = 2'd3;
  end
endmodule

module hazard_tracker #(
  parameter int RA_W = 5,
  parameter int T_W  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] rs_D,
  input  logic [RA_W-1:0] rt_D,
  input  logic [T_W-1:0]  Tuse_rs,
  input  logic [T_W-1:0]  Tuse_rt,
  input  logic [RA_W-1:0] A3_D,
  input  logic [T_W-1:0]  Tnew_D,
  output logic            stall,
  output logic [1:0]      FwdRs_D,
  output logic [1:0]      FwdRt_D,
  output logic [1:0]      FwdRs_E,
  output logic [1:0]      FwdRt_E
);
  localparam int NSRC = 2;  // index 0 = rs, 1 = rt

  logic [RA_W-1:0] A3_E, rs_E, rt_E, A3_M, A3_W;
  logic [T_W-1:0]  Tnew_E, Tnew_M;

  logic [NSRC-1:0][RA_W-1:0] src_d, src_e;
  logic [NSRC-1:0][T_W-1:0]  tuse;
  logic [NSRC-1:0]           stall_src;
  logic [NSRC-1:0][1:0]      fwd_d, fwd_e;

  assign src_d = {rt_D, rs_D};
  assign src_e = {rt_E, rs_E};
  assign tuse  = {Tuse_rt, Tuse_rs};

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    hazard_src #(.RA_W(RA_W), .T_W(T_W)) u_src (
      .src_d  (src_d[g]),
      .tuse   (tuse[g]),
      .src_e  (src_e[g]),
      .a3_e   (A3_E),
      .tnew_e (Tnew_E),
      .a3_m   (A3_M),
      .tnew_m (Tnew_M),
      .a3_w   (A3_W),
      .stall  (stall_src[g]),
      .fwd_d  (fwd_d[g]),
      .fwd_e  (fwd_e[g])
    );
  end

  assign stall   = |stall_src;
  assign FwdRs_D = fwd_d[0];
  assign FwdRt_D = fwd_d[1];
  assign FwdRs_E = fwd_e[0];
  assign FwdRt_E = fwd_e[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      A3_E   <= '0;
      Tnew_E <= '0;
      rs_E   <= '0;
      rt_E   <= '0;
      A3_M   <= '0;
      Tnew_M <= '0;
      A3_W   <= '0;
    end else begin
      A3_W   <= A3_M;
      A3_M   <= A3_E;
      // Saturating decrement: a ready result stays ready.
      Tnew_M <= (Tnew_E == '0) ? '0 : Tnew_E - T_W'(1);
      if (stall) begin
        A3_E   <= '0;
        Tnew_E <= '0;
        rs_E   <= '0;
        rt_E   <= '0;
      end else begin
        A3_E   <= A3_D;
        Tnew_E <= Tnew_D;
        rs_E   <= rs_D;
        rt_E   <= rt_D;
      end
    end
  end
endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: each scenario task drives D-stage
// instructions cycle by cycle and compares outputs against hand-derived values.
module tb_hazard_tracker;
  logic       clk, reset;
  logic [4:0] rs_D, rt_D, A3_D;
  logic [2:0] Tuse_rs, Tuse_rt, Tnew_D;
  logic       stall;
  logic [1:0] FwdRs_D, FwdRt_D, FwdRs_E, FwdRt_E;

  int n_checks = 0;
  int n_pass   = 0;

  hazard_tracker #(.RA_W(5), .T_W(3)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt),
    .A3_D(A3_D), .Tnew_D(Tnew_D),
    .stall(stall), .FwdRs_D(FwdRs_D), .FwdRt_D(FwdRt_D),
    .FwdRs_E(FwdRs_E), .FwdRt_E(FwdRt_E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a D instruction, let combinational outputs settle (away from edge).
  task automatic set_d(input logic [4:0] rs, input logic [2:0] tu_rs,
                       input logic [4:0] rt, input logic [2:0] tu_rt,
                       input logic [4:0] a3, input logic [2:0] tn);
    rs_D = rs; Tuse_rs = tu_rs; rt_D = rt; Tuse_rt = tu_rt;
    A3_D = a3; Tnew_D = tn;
    #2;
  endtask

  task automatic nop();
    set_d(5'd0, 3'd7, 5'd0, 3'd7, 5'd0, 3'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nop();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_d(5'($urandom), 3'($urandom), 5'($urandom), 3'($urandom),
            5'($urandom), 3'($urandom_range(0, 2)));
      n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else n_pass++;
      n_checks++;
      if ({FwdRs_D, FwdRt_D, FwdRs_E, FwdRt_E} !== 8'h00)
        $display("FAIL reset_fwd: got %h want 00", {FwdRs_D, FwdRt_D, FwdRs_E, FwdRt_E});
      else n_pass++;
      tick();
    end
    nop(); tick();
    reset = 1'b1;
    #1;
    set_d(5'd5, 3'd1, 5'd0, 3'd7, 5'd0, 3'd1);
    n_checks++; if (stall !== 1'b0) $display("FAIL post_reset_stall: got %b want 0", stall); else n_pass++;
    n_checks++; if (FwdRs_D !== 2'd0) $display("FAIL post_reset_fwd: got %0d want 0", FwdRs_D); else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_d(5'd29, 3'd1, 5'd0, 3'd7, 5'd3, 3'd2);          // lw $3
    n_checks++; if (stall !== 1'b0) $display("FAIL lu_first: got %b want 0", stall); else n_pass++;
    tick();
    set_d(5'd3, 3'd1, 5'd0, 3'd7, 5'd8, 3'd1);           // add $8,$3,$0
    n_checks++; if (stall !== 1'b1) $display("FAIL lu_stall: got %b want 1", stall); else n_pass++;
    tick();
    n_checks++; if (stall !== 1'b0) $display("FAIL lu_release: got %b want 0", stall); else n_pass++;
    n_checks++; if (FwdRs_D !== 2'd0) $display("FAIL lu_fwd_d: got %0d want 0", FwdRs_D); else n_pass++;
    tick();
    nop();
    n_checks++; if (FwdRs_E !== 2'd3) $display("FAIL lu_fwd_e: got %0d want 3", FwdRs_E); else n_pass++;
    tick();
  endtask

  task automatic test_load_beq();
    do_reset();
    set_d(5'd29, 3'd1, 5'd0, 3'd7, 5'd4, 3'd2);          // lw $4
    tick();
    set_d(5'd4, 3'd0, 5'd5, 3'd0, 5'd0, 3'd0);           // beq $4,$5
    n_checks++; if (stall !== 1'b1) $display("FAIL lb_stall1: got %b want 1", stall); else n_pass++;
    tick();
    n_checks++; if (stall !== 1'b1) $display("FAIL lb_stall2: got %b want 1", stall); else n_pass++;
    tick();
    n_checks++; if (stall !== 1'b0) $display("FAIL lb_release: got %b want 0", stall); else n_pass++;
    n_checks++; if (FwdRs_D !== 2'd3) $display("FAIL lb_fwd_rs: got %0d want 3", FwdRs_D); else n_pass++;
    n_checks++; if (FwdRt_D !== 2'd0) $display("FAIL lb_fwd_rt: got %0d want 0", FwdRt_D); else n_pass++;
    tick();
  endtask

  task automatic test_alu_alu();
    do_reset();
    set_d(5'd1, 3'd1, 5'd2, 3'd1, 5'd7, 3'd1);           // add $7
    tick();
    set_d(5'd9, 3'd1, 5'd7, 3'd1, 5'd10, 3'd1);          // sub $10,$9,$7
    n_checks++; if (stall !== 1'b0) $display("FAIL aa_stall: got %b want 0", stall); else n_pass++;
    n_checks++; if (FwdRt_D !== 2'd0) $display("FAIL aa_fwd_d: got %0d want 0", FwdRt_D); else n_pass++;
    tick();
    nop();
    n_checks++; if (FwdRt_E !== 2'd2) $display("FAIL aa_fwd_rt_e: got %0d want 2", FwdRt_E); else n_pass++;
    n_checks++; if (FwdRs_E !== 2'd0) $display("FAIL aa_fwd_rs_e: got %0d want 0", FwdRs_E); else n_pass++;
    tick();
  endtask

  task automatic test_jal_jr();
    do_reset();
    set_d(5'd0, 3'd7, 5'd0, 3'd7, 5'd31, 3'd0);          // jal
    tick();
    set_d(5'd31, 3'd0, 5'd0, 3'd7, 5'd0, 3'd0);          // jr $31
    n_checks++; if (stall !== 1'b0) $display("FAIL jr_stall: got %b want 0", stall); else n_pass++;
    n_checks++; if (FwdRs_D !== 2'd1) $display("FAIL jr_fwd_e: got %0d want 1", FwdRs_D); else n_pass++;
    tick();
    // jal now in M with Tnew saturated at 0
    n_checks++; if (FwdRs_D !== 2'd2) $display("FAIL jr_fwd_m: got %0d want 2", FwdRs_D); else n_pass++;
    tick();
    n_checks++; if (FwdRs_D !== 2'd3) $display("FAIL jr_fwd_w: got %0d want 3", FwdRs_D); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_d(5'd1, 3'd1, 5'd0, 3'd7, 5'd2, 3'd1);           // ori $2
    tick();
    set_d(5'd29, 3'd1, 5'd0, 3'd7, 5'd2, 3'd2);          // lw $2
    n_checks++; if (stall !== 1'b0) $display("FAIL pr_lw_stall: got %b want 0", stall); else n_pass++;
    tick();
    set_d(5'd2, 3'd1, 5'd0, 3'd7, 5'd11, 3'd1);          // add $11,$2,$0
    n_checks++; if (stall !== 1'b1) $display("FAIL pr_stall: got %b want 1", stall); else n_pass++;
    n_checks++; if (FwdRs_D !== 2'd0) $display("FAIL pr_fwd_stall: got %0d want 0", FwdRs_D); else n_pass++;
    tick();
    n_checks++; if (stall !== 1'b0) $display("FAIL pr_release: got %b want 0", stall); else n_pass++;
    n_checks++; if (FwdRs_D !== 2'd0) $display("FAIL pr_fwd_d: got %0d want 0", FwdRs_D); else n_pass++;
    tick();
    nop();
    n_checks++; if (FwdRs_E !== 2'd3) $display("FAIL pr_fwd_e: got %0d want 3", FwdRs_E); else n_pass++;
    tick();
  endtask

  task automatic test_zero_and_self();
    do_reset();
    set_d(5'd0, 3'd0, 5'd0, 3'd0, 5'd0, 3'd2);           // writes $0, lw latency
    tick();
    set_d(5'd0, 3'd0, 5'd0, 3'd0, 5'd1, 3'd1);           // reads $0 vs A3_E=0
    n_checks++; if (stall !== 1'b0) $display("FAIL r0_stall: got %b want 0", stall); else n_pass++;
    n_checks++; if ({FwdRs_D, FwdRt_D} !== 4'h0) $display("FAIL r0_fwd: got %h want 0", {FwdRs_D, FwdRt_D}); else n_pass++;
    do_reset();
    set_d(5'd1, 3'd1, 5'd2, 3'd1, 5'd1, 3'd1);           // add $1,$1,$2
    n_checks++; if (stall !== 1'b0) $display("FAIL self_stall: got %b want 0", stall); else n_pass++;
    n_checks++; if (FwdRs_D !== 2'd0) $display("FAIL self_fwd: got %0d want 0", FwdRs_D); else n_pass++;
    tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    set_d(5'd29, 3'd1, 5'd0, 3'd7, 5'd3, 3'd2);          // lw $3
    tick();
    set_d(5'd3, 3'd1, 5'd0, 3'd7, 5'd8, 3'd1);           // dependent add
    n_checks++; if (stall !== 1'b1) $display("FAIL mr_pre: got %b want 1", stall); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL mr_async: got %b want 0", stall); else n_pass++;
    tick();
    reset = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL mr_after: got %b want 0", stall); else n_pass++;
    n_checks++; if (FwdRs_D !== 2'd0) $display("FAIL mr_fwd: got %0d want 0", FwdRs_D); else n_pass++;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    nop();
    test_reset();
    test_load_use();
    test_load_beq();
    test_alu_alu();
    test_jal_jr();
    test_back_to_back();
    test_zero_and_self();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Consumer side of the decode-stage Tuse/Tnew handshake in the 5-stage MIPS pipeline (P5).
- The decode controller publishes source registers and Tuse; this block keeps a shadow pipeline of destination register and Tnew for the E, M and W stages.
- Each cycle it decides stall versus forward for the instruction in D and for the instruction in E.
- It sits beside the D/E/M/W pipeline registers and drives their stall/bubble controls and the forwarding muxes.

Parameters:
- RA_W, 5, register-address width.
- T_W, 3, width of Tuse/Tnew fields; all-ones (7) means "operand not used".

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rs_D  in  RA_W  rs field of the instruction in D.
- rt_D  in  RA_W  rt field of the instruction in D.
- Tuse_rs  in  T_W  cycles until D consumes rs (0 = in D, 1 = in E, 2 = in M, 7 = unused).
- Tuse_rt  in  T_W  same for rt.
- A3_D  in  RA_W  destination register of the D instruction; 0 = no write.
- Tnew_D  in  T_W  result latency measured at E entry: ALU/lui 1, lw 2, jal 0.
- stall  out  1  hold PC and IF/ID; insert a bubble into E.
- FwdRs_D  out  2  D-stage rs mux select: 0 RF, 1 from E, 2 from M, 3 from W.
- FwdRt_D  out  2  same for rt.
- FwdRs_E  out  2  E-stage rs mux select: 0 pipeline reg, 2 from M, 3 from W.
- FwdRt_E  out  2  same for rt.

Behaviour:
- State registers: A3_E, Tnew_E, rs_E, rt_E, A3_M, Tnew_M, A3_W. Tnew_W is implicitly 0.
- Reset (reset=0, asynchronous) clears every state register to 0. Combinationally this gives stall=0 and all Fwd* = 0 while reset is held.
- Every rising edge when not in reset, the shadow pipeline advances:
  - A3_W <= A3_M.
  - A3_M <= A3_E.
  - Tnew_M <= (Tnew_E == 0) ? 0 : Tnew_E - 1, saturating, never wraps.
- E entry on the same edge:
  - If stall=0: A3_E <= A3_D, Tnew_E <= Tnew_D, rs_E <= rs_D, rt_E <= rt_D.
  - If stall=1: A3_E, Tnew_E, rs_E and rt_E all load 0 (bubble).
- Stall (combinational). For X in {rs, rt}:
  - stall_X = (X_D != 0) and ((X_D == A3_E and Tuse_X < Tnew_E) or (X_D == A3_M and Tuse_X < Tnew_M)).
  - stall = stall_rs | stall_rt.
  - Tuse = 7 never stalls, because Tnew never exceeds 2.
- Register $0 never matches, never stalls, and is never forwarded.
- D forwarding uses the youngest matching stage (E over M over W):
  - E match with Tnew_E == 0 → 1. E match with Tnew_E != 0 → 0 (stale; value is picked up later in E).
  - Else M match with Tnew_M == 0 → 2; M match with Tnew_M != 0 → 0.
  - Else W match → 3.
  - Else 0.
- E forwarding compares rs_E/rt_E against M then W, with the same youngest-first rule:
  - M match with Tnew_M == 0 → 2; M match with Tnew_M != 0 → 0.
  - Else W match → 3.
  - Else 0.
- Fwd* values are meaningful only when stall=0. When stall=1 they still follow the rules above and downstream logic ignores them.
- Simultaneous events: an instruction reading and writing the same register (e.g. add $1,$1,$2) compares only against older stages, never against its own A3_D.
- Back-to-back stalls: each stall cycle inserts one further bubble. The D inputs are held by the caller, so stall deasserts exactly when the older Tnew has decremented enough.
- Reset mid-operation: all in-flight entries are discarded immediately. There is no stall on the first cycle after release.

Test Plan:
- Reset: drive reset=0 with random D inputs → stall=0, all Fwd*=0. Release, then a D instruction with rs_D=5, A3_D=0 → no stall, FwdRs_D=0.
- Load-use: lw $3 (A3_D=3, Tnew_D=2), then add rs=3 with Tuse_rs=1 → stall=1 for exactly 1 cycle. Next cycle stall=0, FwdRs_D=0, and the following cycle FwdRs_E=3 (lw in W).
- Load-beq: lw $4, then beq rs=4 with Tuse_rs=0 → stall for 2 cycles. Then FwdRs_D=3.
- ALU-to-ALU: add $7, then sub rt=7 with Tuse_rt=1 → no stall, FwdRt_D=0. Next cycle FwdRt_E=2.
- jal then jr $31: jal A3_D=31, Tnew_D=0; jr Tuse_rs=0 → no stall, FwdRs_D=1.
- Priority and $0: ori $2 then lw $2 back-to-back, then add rs=2, Tuse 1 → stall 1 cycle (youngest is lw), never forwards from the older ori. Separately, an instruction with rs_D=0 against A3_E=0 bubble → stall=0, FwdRs_D=0.
